// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg
// Shared AXI4-Lite definitions: response codes and the 1-bit state encodings
// of the subordinate's write and read FSMs. Also used by the master side to
// decode BRESP/RRESP.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile
// NUM_REGS x DATA_WIDTH register bank with one byte-strobed write port and
// one combinational read port.
// Ports:
//   ACLK, ARESETN        clock, async active-low reset (clears all registers)
//   wr_en/wr_idx         write enable and word index (index must be in range)
//   wr_data/wr_strb      write data and per-byte enables
//   rd_idx/rd_data       combinational read port
//   reg_out              flat register contents, reg i at [32i+31:32i]
//   reg_wr               one-cycle pulse the cycle after reg i is written
module axi4_lite_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0]                 reg_wr_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q   <= '0;
            reg_wr_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                reg_wr_q[i] <= wr_en && (wr_idx == IDX_W'(i));
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
                        if (wr_strb[b]) begin
                            regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign rd_data = regs_q[rd_idx];
    assign reg_out = regs_q;
    assign reg_wr  = reg_wr_q;

endmodule

// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave
// AXI4-Lite subordinate terminating AW/W/B and AR/R into a register bank.
// Independent write and read FSMs allow one write and one read in flight.
// Ports:
//   ACLK, ARESETN        clock, async active-low reset
//   S_AW*/S_W*/S_B*      write address, write data, write response channels
//   S_AR*/S_R*           read address and read data channels
//   reg_out              flat register contents, reg i at [32i+31:32i]
//   reg_wr               per-register write pulse, cycle after the write
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDRESS-1:0]             S_AWADDR,
    input  logic                           S_AWVALID,
    output logic                           S_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
    input  logic                           S_WVALID,
    output logic                           S_WREADY,
    output logic [1:0]                     S_BRESP,
    output logic                           S_BVALID,
    input  logic                           S_BREADY,
    input  logic [ADDRESS-1:0]             S_ARADDR,
    input  logic                           S_ARVALID,
    output logic                           S_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_RDATA,
    output logic [1:0]                     S_RRESP,
    output logic                           S_RVALID,
    input  logic                           S_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int unsigned IDX_W    = ADDRESS - 2;
    localparam int unsigned REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;

    // Write path state
    wr_state_e             wr_state_q;
    logic                  aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0]            b_resp_q;
    logic                  aw_done_q, w_done_q;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    // Read path state
    rd_state_e             rd_state_q;
    logic                  ar_ready_q, r_valid_q;
    logic [1:0]            r_resp_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  have_aw, have_w, wr_commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_in_range, rd_in_range;
    logic [DATA_WIDTH-1:0] wr_data, rf_rd_data;
    logic [STRB_W-1:0]     wr_strb;

    // Byte-offset bits of both addresses do not take part in decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

    assign aw_hs   = S_AWVALID & aw_ready_q;
    assign w_hs    = S_WVALID & w_ready_q;
    assign ar_hs   = S_ARVALID & ar_ready_q;
    assign have_aw = aw_hs | aw_done_q;
    assign have_w  = w_hs | w_done_q;

    // Commit on the edge that captures the later of AW/W, using the live
    // channel values when that channel is handshaking this cycle.
    assign wr_commit   = (wr_state_q == WR_IDLE) & have_aw & have_w;
    assign wr_idx      = aw_hs ? S_AWADDR[ADDRESS-1:2] : aw_idx_q;
    assign wr_data     = w_hs ? S_WDATA : w_data_q;
    assign wr_strb     = w_hs ? S_WSTRB : w_strb_q;
    assign wr_in_range = wr_idx < IDX_W'(NUM_REGS);

    assign rd_idx      = S_ARADDR[ADDRESS-1:2];
    assign rd_in_range = rd_idx < IDX_W'(NUM_REGS);

    axi4_lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (REG_IDX_W)
    ) u_regfile (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .wr_en   (wr_commit & wr_in_range),
        .wr_idx  (wr_idx[REG_IDX_W-1:0]),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_idx  (rd_idx[REG_IDX_W-1:0]),
        .rd_data (rf_rd_data),
        .reg_out (reg_out),
        .reg_wr  (reg_wr)
    );

    // Write FSM
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= WR_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_idx_q <= S_AWADDR[ADDRESS-1:2];
                    end
                    if (w_hs) begin
                        w_data_q <= S_WDATA;
                        w_strb_q <= S_WSTRB;
                    end
                    if (wr_commit) begin
                        wr_state_q <= WR_RESP;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        // Also raises both readies the first cycle after reset.
                        aw_done_q  <= have_aw;
                        w_done_q   <= have_w;
                        aw_ready_q <= ~have_aw;
                        w_ready_q  <= ~have_w;
                    end
                end
                WR_RESP: begin
                    if (S_BREADY) begin
                        wr_state_q <= WR_IDLE;
                        b_valid_q  <= 1'b0;
                        b_resp_q   <= RESP_OKAY;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read FSM; the bank is sampled before any same-edge write lands.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_q <= RD_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state_q <= RD_DATA;
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        r_resp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        r_data_q   <= rd_in_range ? rf_rd_data : '0;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (S_RREADY) begin
                        rd_state_q <= RD_IDLE;
                        ar_ready_q <= 1'b1;
                        r_valid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign S_AWREADY = aw_ready_q;
    assign S_WREADY  = w_ready_q;
    assign S_BVALID  = b_valid_q;
    assign S_BRESP   = b_resp_q;
    assign S_ARREADY = ar_ready_q;
    assign S_RVALID  = r_valid_q;
    assign S_RRESP   = r_resp_q;
    assign S_RDATA   = r_data_q;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// tb_axi4_lite_slave
// Directed bench for axi4_lite_slave. Inputs are driven and outputs sampled
// on the falling clock edge; expected values are hand-computed constants.
module tb_axi4_lite_slave;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [31:0]  S_AWADDR;
    logic         S_AWVALID;
    logic         S_AWREADY;
    logic [31:0]  S_WDATA;
    logic [3:0]   S_WSTRB;
    logic         S_WVALID;
    logic         S_WREADY;
    logic [1:0]   S_BRESP;
    logic         S_BVALID;
    logic         S_BREADY;
    logic [31:0]  S_ARADDR;
    logic         S_ARVALID;
    logic         S_ARREADY;
    logic [31:0]  S_RDATA;
    logic [1:0]   S_RRESP;
    logic         S_RVALID;
    logic         S_RREADY;
    logic [255:0] reg_out;
    logic [7:0]   reg_wr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] exp_out;
    logic [1:0]   resp;
    logic [7:0]   pulse;
    logic [31:0]  rdata;

    always #5 ACLK = ~ACLK;

    axi4_lite_slave #(
        .ADDRESS    (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (8)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .S_ARADDR  (S_ARADDR),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY),
        .reg_out   (reg_out),
        .reg_wr    (reg_wr)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] bresp,
                             output logic [7:0] wr_pulse);
        bit aw_ok, w_ok, aw_now, w_now;
        int n;
        aw_ok = 0;
        w_ok  = 0;
        S_AWADDR  = addr;
        S_AWVALID = 1'b1;
        S_WDATA   = data;
        S_WSTRB   = strb;
        S_WVALID  = 1'b1;
        n = 0;
        while (!(aw_ok && w_ok) && n < 20) begin
            aw_now = S_AWVALID && S_AWREADY;
            w_now  = S_WVALID && S_WREADY;
            tick();
            n++;
            if (aw_now) begin
                aw_ok = 1;
                S_AWVALID = 1'b0;
            end
            if (w_now) begin
                w_ok = 1;
                S_WVALID = 1'b0;
            end
        end
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        n = 0;
        while (!S_BVALID && n < 20) begin
            tick();
            n++;
        end
        check("wr_bvalid_seen", 256'(S_BVALID), 256'(1));
        bresp    = S_BRESP;
        wr_pulse = reg_wr;
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] rresp);
        bit ar_ok, ar_now;
        int n;
        ar_ok = 0;
        S_ARADDR  = addr;
        S_ARVALID = 1'b1;
        n = 0;
        while (!ar_ok && n < 20) begin
            ar_now = S_ARREADY;
            tick();
            n++;
            if (ar_now) ar_ok = 1;
        end
        S_ARVALID = 1'b0;
        n = 0;
        while (!S_RVALID && n < 20) begin
            tick();
            n++;
        end
        check("rd_rvalid_seen", 256'(S_RVALID), 256'(1));
        data     = S_RDATA;
        rresp    = S_RRESP;
        S_RREADY = 1'b1;
        tick();
        S_RREADY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARESETN   = 1'b0;
        S_AWADDR  = '0;
        S_AWVALID = 1'b0;
        S_WDATA   = '0;
        S_WSTRB   = '0;
        S_WVALID  = 1'b0;
        S_BREADY  = 1'b0;
        S_ARADDR  = '0;
        S_ARVALID = 1'b0;
        S_RREADY  = 1'b0;
        exp_out   = '0;
        tick();
        tick();

        // Reset state
        check("rst_ctrl", 256'({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID}), 256'(0));
        check("rst_resp", 256'({S_BRESP, S_RRESP}), 256'(0));
        check("rst_rdata", 256'(S_RDATA), 256'(0));
        check("rst_reg_out", reg_out, 256'(0));
        check("rst_reg_wr", 256'(reg_wr), 256'(0));
        ARESETN = 1'b1;
        tick();
        check("idle_ready", 256'({S_AWREADY, S_WREADY, S_ARREADY}), 256'(3'b111));

        // T1: AW+W same cycle to reg1
        S_AWADDR = 32'h4; S_AWVALID = 1'b1;
        S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        check("t1_bvalid", 256'(S_BVALID), 256'(1));
        check("t1_bresp", 256'(S_BRESP), 256'(2'b00));
        check("t1_awready_low", 256'({S_AWREADY, S_WREADY}), 256'(0));
        exp_out[63:32] = 32'hDEADBEEF;
        check("t1_reg_out", reg_out, exp_out);
        check("t1_reg_wr", 256'(reg_wr), 256'(8'b0000_0010));
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        check("t1_b_done", 256'(S_BVALID), 256'(0));
        check("t1_reg_wr_clear", 256'(reg_wr), 256'(0));
        check("t1_ready_back", 256'({S_AWREADY, S_WREADY}), 256'(2'b11));

        // T2: preload reg2, then W three cycles ahead of AW with byte-0 strobe
        axi_write(32'h8, 32'h12345678, 4'hF, resp, pulse);
        exp_out[95:64] = 32'h12345678;
        check("t2_pre_resp", 256'(resp), 256'(2'b00));
        check("t2_pre_pulse", 256'(pulse), 256'(8'b0000_0100));
        check("t2_pre_reg", reg_out, exp_out);
        S_WDATA = 32'h000000AA; S_WSTRB = 4'b0001; S_WVALID = 1'b1;
        tick();
        S_WVALID = 1'b0;
        check("t2_wready_low", 256'(S_WREADY), 256'(0));
        check("t2_no_commit", reg_out, exp_out);
        tick();
        tick();
        check("t2_waiting", 256'({S_BVALID, S_WREADY, S_AWREADY}), 256'(3'b001));
        S_AWADDR = 32'h8; S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        check("t2_bvalid", 256'(S_BVALID), 256'(1));
        check("t2_bresp", 256'(S_BRESP), 256'(2'b00));
        exp_out[95:64] = 32'h123456AA;
        check("t2_reg_out", reg_out, exp_out);
        check("t2_reg_wr", 256'(reg_wr), 256'(8'b0000_0100));
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;

        // T3: read reg1 with RREADY held low for 4 cycles
        S_ARADDR = 32'h4; S_ARVALID = 1'b1;
        tick();
        S_ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_rvalid", 256'(S_RVALID), 256'(1));
            check("t3_rdata", 256'(S_RDATA), 256'(32'hDEADBEEF));
            check("t3_rresp", 256'(S_RRESP), 256'(2'b00));
            check("t3_arready_low", 256'(S_ARREADY), 256'(0));
            tick();
        end
        S_RREADY = 1'b1;
        check("t3_rdata_hold", 256'(S_RDATA), 256'(32'hDEADBEEF));
        tick();
        S_RREADY = 1'b0;
        check("t3_r_done", 256'({S_RVALID, S_ARREADY}), 256'(2'b01));

        // T4: out-of-range index 8
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, resp, pulse);
        check("t4_bresp", 256'(resp), 256'(2'b10));
        check("t4_no_pulse", 256'(pulse), 256'(0));
        check("t4_no_change", reg_out, exp_out);
        axi_read(32'h20, rdata, resp);
        check("t4_rresp", 256'(resp), 256'(2'b10));
        check("t4_rdata", 256'(rdata), 256'(0));

        // T5: AR and completing W to reg3 on the same edge
        S_AWADDR = 32'hC; S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        check("t5_aw_only", 256'({S_BVALID, S_AWREADY, S_WREADY}), 256'(3'b001));
        S_WDATA = 32'h55; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        S_ARADDR = 32'hC; S_ARVALID = 1'b1;
        tick();
        S_WVALID = 1'b0; S_ARVALID = 1'b0;
        check("t5_both_valid", 256'({S_BVALID, S_RVALID}), 256'(2'b11));
        check("t5_old_rdata", 256'(S_RDATA), 256'(0));
        exp_out[127:96] = 32'h55;
        check("t5_reg_out", reg_out, exp_out);
        S_BREADY = 1'b1; S_RREADY = 1'b1;
        tick();
        S_BREADY = 1'b0; S_RREADY = 1'b0;
        axi_read(32'hC, rdata, resp);
        check("t5_new_rdata", 256'(rdata), 256'(32'h55));
        check("t5_new_rresp", 256'(resp), 256'(2'b00));

        // T6: reset while BVALID pending
        S_AWADDR = 32'h0; S_AWVALID = 1'b1;
        S_WDATA = 32'h11; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        check("t6_bvalid_pend", 256'(S_BVALID), 256'(1));
        #2 ARESETN = 1'b0;
        #1;
        check("t6_bvalid_drop", 256'(S_BVALID), 256'(0));
        check("t6_regs_clear", reg_out, 256'(0));
        check("t6_ready_clear", 256'({S_AWREADY, S_WREADY, S_ARREADY}), 256'(0));
        tick();
        tick();
        ARESETN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_resp", 256'({S_BVALID, S_RVALID}), 256'(0));
        end
        exp_out = '0;
        axi_write(32'h10, 32'hCAFEF00D, 4'hF, resp, pulse);
        exp_out[159:128] = 32'hCAFEF00D;
        check("t6_post_bresp", 256'(resp), 256'(2'b00));
        check("t6_post_pulse", 256'(pulse), 256'(8'b0001_0000));
        check("t6_post_reg", reg_out, exp_out);
        axi_read(32'h4, rdata, resp);
        check("t6_reg1_cleared", 256'(rdata), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave.md
Name: axi4_lite_slave

Overview:
AXI4-Lite subordinate (responder) terminating the master's five channels into a bank of NUM_REGS 32-bit control/status registers. Write and read paths are independent FSMs, so a read and a write can be in flight concurrently. Register contents are exported flat to the surrounding logic, together with per-register write strobes.

Parameters:
ADDRESS, 32, byte-address width of AW/AR channels
DATA_WIDTH, 32, data bus width; only 32 supported (4 strobe bits)
NUM_REGS, 8, number of 32-bit registers; word-indexed from address 0

Ports:
ACLK  input  1  clock, rising edge
ARESETN  input  1  reset, asynchronous, active-low
S_AWADDR  input  ADDRESS  write address
S_AWVALID  input  1  write address valid
S_AWREADY  output  1  write address ready
S_WDATA  input  DATA_WIDTH  write data
S_WSTRB  input  4  byte enables
S_WVALID  input  1  write data valid
S_WREADY  output  1  write data ready
S_BRESP  output  2  write response
S_BVALID  output  1  write response valid
S_BREADY  input  1  write response ready
S_ARADDR  input  ADDRESS  read address
S_ARVALID  input  1  read address valid
S_ARREADY  output  1  read address ready
S_RDATA  output  DATA_WIDTH  read data
S_RRESP  output  2  read response
S_RVALID  output  1  read data valid
S_RREADY  input  1  read data ready
reg_out  output  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [32i+31:32i]
reg_wr  output  NUM_REGS  one-cycle pulse, cycle after reg i is written (any strobe)

Behaviour:
- Reset (ARESETN low, async): all registers 0; all outputs 0; both FSMs to idle. Reset mid-transaction drops it; no B/R response is issued after reset release.
- Decode: index = ADDR[ADDRESS-1:2]; ADDR[1:0] ignored. index >= NUM_REGS -> out of range.
- Write FSM states: WR_IDLE, WR_RESP.
  - WR_IDLE: S_AWREADY=1 until AW captured; S_WREADY=1 until W captured. AW and W may arrive in either order or the same cycle; each is latched independently.
  - On the edge where the second of AW/W is captured (or both together): the write commits, with byte i of the register updated only where WSTRB[i]=1. The FSM goes to WR_RESP.
  - Next cycle: S_BVALID=1. S_BRESP=00 (OKAY) in range, 10 (SLVERR) out of range. An out-of-range write modifies nothing and pulses no reg_wr.
  - WR_RESP: S_AWREADY=S_WREADY=0. S_BVALID and S_BRESP are held stable until S_BREADY=1, then return to WR_IDLE with S_BVALID=0 next cycle.
  - Minimum write latency: AW+W handshake cycle -> BVALID one cycle later.
- Read FSM states: RD_IDLE, RD_DATA.
  - RD_IDLE: S_ARREADY=1. On the AR handshake, S_RDATA is registered from the bank and the FSM goes to RD_DATA.
  - Next cycle: S_RVALID=1. S_RRESP=00 in range; 10 with RDATA=0 out of range.
  - RD_DATA: S_ARREADY=0. RDATA/RRESP are held stable until S_RREADY=1, then return to RD_IDLE.
  - Read latency: 1 cycle from AR handshake to RVALID.
- Simultaneous AR handshake and write commit to the same register on one edge: the read returns the pre-write value.
- Back-to-back: a new AW/W/AR is accepted no earlier than the cycle after the B/R handshake (one outstanding transaction per direction).
- A VALID raised by the master is never required to wait on the opposite channel.

Decomposition:
- Package axi4_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write FSM enum (WR_IDLE, WR_RESP) and read FSM enum (RD_IDLE, RD_DATA), 1-bit encodings.
  - Shared with the master for response decoding.
- Sub-module axi4_lite_regfile:
  - Holds the NUM_REGS x 32 storage with byte-strobed write port, combinational read port, flat reg_out and reg_wr pulses.
  - The slave owns only the handshakes, address latching and decode.

Test Plan:
- Reset, then AW(0x4)+W(0xDEADBEEF, strb 1111) same cycle -> BVALID next cycle, BRESP=00; reg_out[63:32]=0xDEADBEEF; reg_wr=8'b0000_0010 pulse.
- W (0x000000AA, strb 0001) presented 3 cycles before AW(0x8), reg2 preloaded 0x12345678 -> single commit; reg2=0x123456AA; WREADY low after W capture.
- AR(0x4) with RREADY held low 4 cycles -> RVALID and RDATA=0xDEADBEEF stable throughout, RRESP=00; ARREADY low until the R handshake.
- AW/AR to 0x20 (index 8, NUM_REGS=8) -> BRESP=10 with no register change and no reg_wr; RRESP=10 with RDATA=0.
- AR(0xC) and the completing W to 0xC on the same edge, old 0x0, new 0x55 -> RDATA=0x0, subsequent read returns 0x55.
- ARESETN low while BVALID pending -> BVALID=0 immediately, all registers 0, no response after release; next write completes normally.
